// File: rtl/processador_param_if.sv
// Command/result bundle between an instruction source and the processador_param core.
// The master drives commands; the slave (the core) returns results and flags.
interface processador_param_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int RA = $clog2(NREGS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       opcode;
  logic [RA-1:0]    rd;
  logic [RA-1:0]    rs1;
  logic [RA-1:0]    rs2;
  logic [WIDTH-1:0] imm;
  logic             use_imm;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output cmd_valid, opcode, rd, rs1, rs2, imm, use_imm,
    input  cmd_ready, res_valid, result, flags, illegal
  );

  modport slave (
    input  cmd_valid, opcode, rd, rs1, rs2, imm, use_imm,
    output cmd_ready, res_valid, result, flags, illegal
  );
endinterface

// File: rtl/processador_param.sv
// Parametrised processor core: NREGS x WIDTH register file, ALU with registered {N,V,C,Z}
// flags and carry chaining, and a WIDTH-cycle unsigned shift-add multiplier.
module processador_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic                 clk,
  input logic                 rst,
  processador_param_if.slave  bus_if
);
  localparam int RA = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,  OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5,  OP_NOT = 4'd6,  OP_SHL = 4'd7,  OP_SHR = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9,  OP_ADC = 4'd10, OP_CMP = 4'd11, OP_MUL = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [3:0]         op_q;
  logic [RA-1:0]      rd_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               c_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               res_valid_q, illegal_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;

  logic               accept;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH:0]     sum_w, dif_w;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c, alu_v;
  logic               upd, wr_en, ill;

  assign accept = bus_if.cmd_valid && (state_q == IDLE);
  assign opa    = regs_q[bus_if.rs1];
  assign opb    = bus_if.use_imm ? bus_if.imm : regs_q[bus_if.rs2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus_if.opcode == OP_MUL) ? MUL : EXEC;
      EXEC:    state_d = IDLE;
      MUL:     if (cnt_q == CW'(WIDTH - 1)) state_d = EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Carry-in is only meaningful for ADC; the extra MSB of sum/dif is carry/borrow.
  assign sum_w = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'((op_q == OP_ADC) ? c_q : 1'b0);
  assign dif_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_val = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        alu_val = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_val = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_val = a_q & b_q;
      OP_OR:   alu_val = a_q | b_q;
      OP_XOR:  alu_val = a_q ^ b_q;
      OP_NOT:  alu_val = ~a_q;
      OP_SHL: begin
        alu_val = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_val = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OP_MOV:  alu_val = b_q;
      OP_MUL: begin
        alu_val = acc_q[WIDTH-1:0];
        alu_c   = |acc_q[2*WIDTH-1:WIDTH];
        alu_v   = |acc_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  assign upd   = (op_q >= OP_ADD) && (op_q <= OP_MUL);
  assign wr_en = upd && (op_q != OP_CMP);
  assign ill   = (op_q > OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (accept) begin
        op_q     <= bus_if.opcode;
        rd_q     <= bus_if.rd;
        a_q      <= opa;
        b_q      <= opb;
        c_q      <= flags_q[1];
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, opa};
        mplier_q <= opb;
        cnt_q    <= '0;
      end
      if (state_q == MUL) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        cnt_q    <= cnt_q + 1'b1;
      end
      if (state_q == EXEC) begin
        res_valid_q <= 1'b1;
        illegal_q   <= ill;
        if (upd) begin
          result_q <= alu_val;
          flags_q  <= {alu_val[WIDTH-1], alu_v, alu_c, (alu_val == '0)};
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          regs_q[gi] <= '0;
        else if ((state_q == EXEC) && wr_en && (rd_q == RA'(gi)))
          regs_q[gi] <= alu_val;
      end
    end
  endgenerate

  assign bus_if.cmd_ready = (state_q == IDLE);
  assign bus_if.res_valid = res_valid_q;
  assign bus_if.illegal   = illegal_q;
  assign bus_if.result    = result_q;
  assign bus_if.flags     = flags_q;
endmodule

// File: tb/tb_processador_param.sv
// Directed, table-driven bench for processador_param (WIDTH=8, NREGS=4) plus
// hand sequences for asynchronous reset, held commands during MUL, and reset mid-MUL.
module tb_processador_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processador_param_if #(.WIDTH(8), .NREGS(4)) bus_if ();
  processador_param #(.WIDTH(8), .NREGS(4)) dut (.clk(clk), .rst(rst), .bus_if(bus_if));

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic       ui;
    logic [7:0] res;
    logic [3:0] flg;   // {N,V,C,Z}
    logic       ill;
  } vec_t;

  vec_t vecs [25];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input logic ui);
    bus_if.opcode  = op;
    bus_if.rd      = rd;
    bus_if.rs1     = rs1;
    bus_if.rs2     = rs2;
    bus_if.imm     = imm;
    bus_if.use_imm = ui;
  endtask

  // Called at #1 after an edge with the core idle; returns cycles from accept to res_valid.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm, input logic ui,
                         output int lat);
    drive(op, rd, rs1, rs2, imm, ui);
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.res_valid) lat = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;

    //            op     rd    rs1   rs2   imm    ui    res    flg      ill
    vecs[0]  = '{4'd9,  2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 8'h7F, 4'b0000, 1'b0}; // MOV r1,7F
    vecs[1]  = '{4'd1,  2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 8'h80, 4'b1100, 1'b0}; // ADD overflow
    vecs[2]  = '{4'd9,  2'd1, 2'd0, 2'd0, 8'h03, 1'b1, 8'h03, 4'b0000, 1'b0};
    vecs[3]  = '{4'd9,  2'd3, 2'd0, 2'd0, 8'h05, 1'b1, 8'h05, 4'b0000, 1'b0};
    vecs[4]  = '{4'd2,  2'd0, 2'd1, 2'd3, 8'h00, 1'b0, 8'hFE, 4'b1010, 1'b0}; // SUB borrow
    vecs[5]  = '{4'd11, 2'd0, 2'd3, 2'd3, 8'h00, 1'b0, 8'h00, 4'b0001, 1'b0}; // CMP r3,r3
    vecs[6]  = '{4'd9,  2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 8'hFE, 4'b1000, 1'b0}; // r0 kept
    vecs[7]  = '{4'd9,  2'd0, 2'd0, 2'd0, 8'hFF, 1'b1, 8'hFF, 4'b1000, 1'b0};
    vecs[8]  = '{4'd1,  2'd0, 2'd0, 2'd0, 8'h01, 1'b1, 8'h00, 4'b0011, 1'b0}; // carry out
    vecs[9]  = '{4'd10, 2'd1, 2'd0, 2'd0, 8'h00, 1'b1, 8'h01, 4'b0000, 1'b0}; // ADC uses C
    vecs[10] = '{4'd3,  2'd2, 2'd2, 2'd0, 8'h0F, 1'b1, 8'h0E, 4'b0000, 1'b0};
    vecs[11] = '{4'd4,  2'd2, 2'd2, 2'd0, 8'h81, 1'b1, 8'h8F, 4'b1000, 1'b0};
    vecs[12] = '{4'd5,  2'd3, 2'd2, 2'd2, 8'h00, 1'b0, 8'h00, 4'b0001, 1'b0};
    vecs[13] = '{4'd6,  2'd3, 2'd3, 2'd0, 8'h00, 1'b1, 8'hFF, 4'b1000, 1'b0};
    vecs[14] = '{4'd7,  2'd3, 2'd3, 2'd0, 8'h00, 1'b1, 8'hFE, 4'b1010, 1'b0};
    vecs[15] = '{4'd8,  2'd3, 2'd3, 2'd0, 8'h00, 1'b1, 8'h7F, 4'b0000, 1'b0};
    vecs[16] = '{4'd8,  2'd1, 2'd1, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0011, 1'b0};
    vecs[17] = '{4'd0,  2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0011, 1'b0}; // NOP holds
    vecs[18] = '{4'd14, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0011, 1'b1}; // illegal
    vecs[19] = '{4'd2,  2'd0, 2'd3, 2'd0, 8'h80, 1'b1, 8'hFF, 4'b1110, 1'b0}; // SUB ovf
    vecs[20] = '{4'd10, 2'd2, 2'd3, 2'd0, 8'h00, 1'b1, 8'h80, 4'b1100, 1'b0}; // ADC ovf
    vecs[21] = '{4'd9,  2'd3, 2'd0, 2'd0, 8'h0F, 1'b1, 8'h0F, 4'b0000, 1'b0};
    vecs[22] = '{4'd12, 2'd0, 2'd3, 2'd3, 8'h00, 1'b0, 8'hE1, 4'b1000, 1'b0}; // MUL 15*15
    vecs[23] = '{4'd12, 2'd0, 2'd3, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0001, 1'b0}; // MUL by 0
    vecs[24] = '{4'd9,  2'd1, 2'd0, 2'd0, 8'h10, 1'b1, 8'h10, 4'b0000, 1'b0};

    bus_if.cmd_valid = 1'b0;
    drive(4'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_result",    32'(bus_if.result),    32'd0);
    chk("rst_flags",     32'(bus_if.flags),     32'd0);
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    rst = 1'b0;

    // Asynchronous reset while res_valid is high, then r1 must read back as zero.
    run_cmd(4'd9, 2'd1, 2'd0, 2'd0, 8'h85, 1'b1, lat);
    chk("load_r1_result", 32'(bus_if.result), 32'h85);
    chk("load_r1_flags",  32'(bus_if.flags),  32'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("async_result",    32'(bus_if.result),    32'd0);
    chk("async_flags",     32'(bus_if.flags),     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_cmd(4'd1, 2'd2, 2'd1, 2'd0, 8'h00, 1'b1, lat);
    chk("post_rst_r1",    32'(bus_if.result), 32'h00);
    chk("post_rst_flags", 32'(bus_if.flags),  32'b0001);
    $display("txn reset: r1 after reset reads %02h flags=%b", bus_if.result, bus_if.flags);

    for (int i = 0; i < 25; i++) begin
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].ui, lat);
      $display("txn %0d: op=%0d result=%02h flags=%b illegal=%0b latency=%0d",
               i, vecs[i].op, bus_if.result, bus_if.flags, bus_if.illegal, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].op == 4'd12) ? 32'd9 : 32'd1);
      chk($sformatf("v%0d_result",  i), 32'(bus_if.result),  32'(vecs[i].res));
      chk($sformatf("v%0d_flags",   i), 32'(bus_if.flags),   32'(vecs[i].flg));
      chk($sformatf("v%0d_illegal", i), 32'(bus_if.illegal), 32'(vecs[i].ill));
    end

    // MUL 0x10*0x11 with the next command held on cmd_valid throughout.
    drive(4'd12, 2'd2, 2'd1, 2'd0, 8'h11, 1'b1);
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 drive(4'd9, 2'd3, 2'd0, 2'd0, 8'h42, 1'b1);
    cnt = 0;
    if (!bus_if.cmd_ready && !bus_if.res_valid) cnt++;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (!bus_if.cmd_ready && !bus_if.res_valid) cnt++;
    end
    chk("mul_busy_cycles", 32'(cnt), 32'd9);
    @(posedge clk);
    #1;
    chk("mul_res_valid", 32'(bus_if.res_valid), 32'd1);
    chk("mul_result",    32'(bus_if.result),    32'h10);
    chk("mul_flags",     32'(bus_if.flags),     32'b0110);
    chk("mul_ready_end", 32'(bus_if.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    chk("mul_pulse_width", 32'(bus_if.res_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("held_cmd_valid",  32'(bus_if.res_valid), 32'd1);
    chk("held_cmd_result", 32'(bus_if.result),    32'h42);
    $display("txn mul_held: mul result 10, held MOV result=%02h", bus_if.result);
    run_cmd(4'd9, 2'd0, 2'd0, 2'd2, 8'h00, 1'b0, lat);
    chk("mul_writeback_r2", 32'(bus_if.result), 32'h10);

    // Reset four cycles into a MUL: the command must vanish without a result.
    drive(4'd12, 2'd3, 2'd1, 2'd0, 8'h11, 1'b1);
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.cmd_valid = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus_if.res_valid) cnt++;
    end
    rst = 1'b1;
    #1;
    chk("midmul_ready",  32'(bus_if.cmd_ready), 32'd1);
    chk("midmul_result", 32'(bus_if.result),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus_if.res_valid) cnt++;
    end
    chk("midmul_no_res_valid", 32'(cnt), 32'd0);
    run_cmd(4'd9, 2'd0, 2'd0, 2'd3, 8'h00, 1'b0, lat);
    chk("midmul_rd_zero", 32'(bus_if.result), 32'h00);
    chk("midmul_flags",   32'(bus_if.flags),  32'b0001);
    $display("txn reset_mid_mul: r3=%02h", bus_if.result);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
